// File: rtl/projectile_ctrl.sv
// Bullet controller for the turret game.
// One bullet at a time: fired on a space-bar press, it flies out along the
// selected turret angle, bounces off the top and bottom walls, turns back at
// the right wall or a deflector, and is retired near the left edge or after a
// fixed number of frames. A cooldown then blocks the next shot.
// Every register advances once per frame on frame_clk.
module projectile_ctrl #(
  parameter int LAUNCH_X   = 90,
  parameter int LAUNCH_Y   = 52,
  parameter int COOLDOWN   = 30,
  parameter int MAX_FLIGHT = 255
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [3:0] turret_sel,
  input  logic       hit_deflector,
  output logic [9:0] b_pos_x,
  output logic [9:0] b_pos_y,
  output logic       b_exist,
  output logic       b_dir,
  output logic [7:0] hit_count
);

  // Playfield geometry, in 11-bit two's complement so that a step past
  // either edge is visible as a sign bit or an oversize value.
  localparam logic [7:0]  KEY_FIRE   = 8'h2C;
  localparam logic [9:0]  HOME_X     = 10'(LAUNCH_X);
  localparam logic [9:0]  HOME_Y     = 10'(LAUNCH_Y);
  localparam logic [10:0] WALL_X     = 11'd599;
  localparam logic [10:0] RETIRE_X   = 11'd10;
  localparam logic [10:0] FLOOR_Y    = 11'd469;
  localparam logic [15:0] FLIGHT_LIM = 16'(MAX_FLIGHT);
  localparam logic [15:0] CD_INIT    = 16'(COOLDOWN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLY    = 2'd1,
    RETURN = 2'd2,
    CDOWN  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [9:0]  x_reg, x_next;
  logic [9:0]  y_reg, y_next;
  logic [3:0]  vx_reg, vx_next;       // signed, pixels per frame
  logic [3:0]  vy_reg, vy_next;       // signed, pixels per frame
  logic        exist_reg, exist_next;
  logic        dir_reg, dir_next;
  logic [7:0]  hits_reg, hits_next;
  logic [15:0] flight_reg, flight_next;
  logic [15:0] cd_reg, cd_next;
  logic [7:0]  key_prev_reg;

  logic        fire;
  logic [3:0]  sel_eff;
  logic [3:0]  launch_vx, launch_vy;
  logic [10:0] nx, ny;
  logic [9:0]  y_step;
  logic [3:0]  vy_step;
  logic [15:0] flight_inc;
  logic        flight_done;
  logic        at_wall;
  logic        at_home;
  logic        retire;

  // Fire is a press, not a level: holding the space bar launches once.
  assign fire = (keycode == KEY_FIRE) && (key_prev_reg != KEY_FIRE);

  // Out-of-range turret indices fall back to the horizontal shot.
  assign sel_eff = (turret_sel > 4'd8) ? 4'd4 : turret_sel;

  // Launch velocity per turret angle (x right-positive, y down-positive).
  always_comb begin
    launch_vx = 4'd4;
    launch_vy = 4'd0;
    case (sel_eff)
      4'd0: begin launch_vx = 4'd0; launch_vy = 4'hC; end  // ( 0,-4)
      4'd1: begin launch_vx = 4'd2; launch_vy = 4'hD; end  // ( 2,-3)
      4'd2: begin launch_vx = 4'd3; launch_vy = 4'hD; end  // ( 3,-3)
      4'd3: begin launch_vx = 4'd4; launch_vy = 4'hE; end  // ( 4,-2)
      4'd4: begin launch_vx = 4'd4; launch_vy = 4'd0; end  // ( 4, 0)
      4'd5: begin launch_vx = 4'd4; launch_vy = 4'd2; end  // ( 4, 2)
      4'd6: begin launch_vx = 4'd3; launch_vy = 4'd3; end  // ( 3, 3)
      4'd7: begin launch_vx = 4'd2; launch_vy = 4'd3; end  // ( 2, 3)
      4'd8: begin launch_vx = 4'd0; launch_vy = 4'd4; end  // ( 0, 4)
      default: begin launch_vx = 4'd4; launch_vy = 4'd0; end
    endcase
  end

  // Candidate next position: unsigned position plus sign-extended velocity.
  assign nx = {1'b0, x_reg} + {{7{vx_reg[3]}}, vx_reg};
  assign ny = {1'b0, y_reg} + {{7{vy_reg[3]}}, vy_reg};

  assign at_wall = !nx[10] && (nx >= WALL_X);
  assign at_home = nx[10] || (nx <= RETIRE_X);

  assign flight_inc  = flight_reg + 16'd1;
  assign flight_done = (flight_inc >= FLIGHT_LIM);

  // Vertical step with clamping and reflection off the top and bottom walls.
  always_comb begin
    y_step  = ny[9:0];
    vy_step = vy_reg;
    if (ny[10]) begin
      y_step  = 10'd0;
      vy_step = 4'd0 - vy_reg;
    end else if (ny > FLOOR_Y) begin
      y_step  = FLOOR_Y[9:0];
      vy_step = 4'd0 - vy_reg;
    end
  end

  // Next-state and datapath update for one frame.
  always_comb begin
    state_next  = state_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    vx_next     = vx_reg;
    vy_next     = vy_reg;
    exist_next  = exist_reg;
    dir_next    = dir_reg;
    hits_next   = hits_reg;
    flight_next = flight_reg;
    cd_next     = cd_reg;
    retire      = 1'b0;

    case (state_reg)
      IDLE: begin
        // The loaded velocity is the latched copy of the turret angle, so
        // later turret moves cannot steer a bullet already in the air.
        if (fire) begin
          vx_next     = launch_vx;
          vy_next     = launch_vy;
          x_next      = HOME_X;
          y_next      = HOME_Y;
          exist_next  = 1'b1;
          dir_next    = 1'b0;
          flight_next = 16'd0;
          state_next  = FLY;
        end
      end

      FLY: begin
        flight_next = flight_inc;
        if (flight_done) begin
          retire = 1'b1;
        end else begin
          y_next  = y_step;
          vy_next = vy_step;
          if (hit_deflector) begin
            // A deflector hit wins over a simultaneous wall hit: the bullet
            // turns around once, in place, and the hit is counted.
            vx_next    = 4'd0 - vx_reg;
            vy_next    = 4'd0 - vy_step;
            dir_next   = 1'b1;
            hits_next  = (hits_reg != 8'hFF) ? hits_reg + 8'd1 : hits_reg;
            state_next = RETURN;
          end else if (at_wall) begin
            x_next     = WALL_X[9:0];
            vx_next    = 4'd0 - vx_reg;
            dir_next   = 1'b1;
            state_next = RETURN;
          end else begin
            x_next = nx[9:0];
          end
        end
      end

      RETURN: begin
        // Deflector contacts are not looked at on the way back.
        flight_next = flight_inc;
        if (flight_done || at_home) begin
          retire = 1'b1;
        end else begin
          x_next  = nx[9:0];
          y_next  = y_step;
          vy_next = vy_step;
        end
      end

      CDOWN: begin
        // Leave on the frame the count reaches zero; a zero preset still
        // spends one frame here.
        if (cd_reg <= 16'd1) begin
          cd_next    = 16'd0;
          state_next = IDLE;
        end else begin
          cd_next = cd_reg - 16'd1;
        end
      end

      default: state_next = IDLE;
    endcase

    // Retirement parks the bullet at the launch point and starts cooldown.
    if (retire) begin
      exist_next = 1'b0;
      x_next     = HOME_X;
      y_next     = HOME_Y;
      dir_next   = 1'b0;
      vx_next    = 4'd0;
      vy_next    = 4'd0;
      cd_next    = CD_INIT;
      state_next = CDOWN;
    end
  end

  // Frame register; reset overrides everything else happening this frame.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_reg    <= IDLE;
      x_reg        <= HOME_X;
      y_reg        <= HOME_Y;
      vx_reg       <= 4'd0;
      vy_reg       <= 4'd0;
      exist_reg    <= 1'b0;
      dir_reg      <= 1'b0;
      hits_reg     <= 8'd0;
      flight_reg   <= 16'd0;
      cd_reg       <= 16'd0;
      key_prev_reg <= 8'h00;
    end else begin
      state_reg    <= state_next;
      x_reg        <= x_next;
      y_reg        <= y_next;
      vx_reg       <= vx_next;
      vy_reg       <= vy_next;
      exist_reg    <= exist_next;
      dir_reg      <= dir_next;
      hits_reg     <= hits_next;
      flight_reg   <= flight_next;
      cd_reg       <= cd_next;
      key_prev_reg <= keycode;
    end
  end

  assign b_pos_x   = x_reg;
  assign b_pos_y   = y_reg;
  assign b_exist   = exist_reg;
  assign b_dir     = dir_reg;
  assign hit_count = hits_reg;

endmodule

// File: tb/tb_projectile_ctrl.sv
// Testbench for projectile_ctrl: a constant vector table, hand-written
// sequences for the long-flight corners, and a randomized run checked every
// frame against a behavioural model. Two instances are driven in parallel:
// one with default parameters and one with a longer flight limit so a full
// out-and-back trip is observable.
module tb_projectile_ctrl;

  localparam int KEY_SPACE = 44;   // 8'h2C
  localparam int LONG_FLIGHT = 400;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic [3:0] turret_sel;
  logic       hit_deflector;

  logic [9:0] ax, ay, bx, by;
  logic       ae, ad, be, bd;
  logic [7:0] ah, bh;

  int vectors = 0;
  int miscompares = 0;

  always #5 frame_clk = ~frame_clk;

  projectile_ctrl dut_a (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
    .turret_sel(turret_sel), .hit_deflector(hit_deflector),
    .b_pos_x(ax), .b_pos_y(ay), .b_exist(ae), .b_dir(ad), .hit_count(ah)
  );

  projectile_ctrl #(.MAX_FLIGHT(LONG_FLIGHT)) dut_b (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
    .turret_sel(turret_sel), .hit_deflector(hit_deflector),
    .b_pos_x(bx), .b_pos_y(by), .b_exist(be), .b_dir(bd), .hit_count(bh)
  );

  // ---------------- behavioural model ----------------
  // phase: 0 waiting for a shot, 1 outbound, 2 coming back, 3 cooling down
  typedef struct {
    int phase;
    int x, y, vx, vy;
    int exist, dir, hits;
    int frames, cool, last_key;
  } model_t;

  model_t ma, mb;
  int vx_tab[9] = '{0, 2, 3, 4, 4, 4, 3, 2, 0};
  int vy_tab[9] = '{-4, -3, -3, -2, 0, 2, 3, 3, 4};

  function automatic model_t model_reset();
    model_t m;
    m.phase = 0; m.x = 90; m.y = 52; m.vx = 0; m.vy = 0;
    m.exist = 0; m.dir = 0; m.hits = 0;
    m.frames = 0; m.cool = 0; m.last_key = 0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, int key, int sel, bit hit,
                                        bit rst, int max_frames);
    model_t n;
    int a, px, py;
    bit done;
    if (rst) return model_reset();
    n = m;
    done = 1'b0;
    n.last_key = key;
    if (m.phase == 0) begin
      if (key == KEY_SPACE && m.last_key != KEY_SPACE) begin
        a = (sel > 8) ? 4 : sel;
        n.vx = vx_tab[a]; n.vy = vy_tab[a];
        n.x = 90; n.y = 52; n.exist = 1; n.dir = 0; n.frames = 0;
        n.phase = 1;
      end
    end else if (m.phase == 1 || m.phase == 2) begin
      n.frames = m.frames + 1;
      if (n.frames >= max_frames) begin
        done = 1'b1;
      end else begin
        px = m.x + m.vx;
        py = m.y + m.vy;
        if (py < 0) begin n.y = 0; n.vy = -m.vy; end
        else if (py > 469) begin n.y = 469; n.vy = -m.vy; end
        else n.y = py;
        if (m.phase == 1) begin
          if (hit) begin
            n.vx = -m.vx; n.vy = -n.vy; n.dir = 1; n.phase = 2;
            if (m.hits < 255) n.hits = m.hits + 1;
          end else if (px >= 599) begin
            n.x = 599; n.vx = -m.vx; n.dir = 1; n.phase = 2;
          end else begin
            n.x = px;
          end
        end else begin
          if (px <= 10) done = 1'b1;
          else n.x = px;
        end
      end
    end else begin
      if (m.cool <= 1) begin n.cool = 0; n.phase = 0; end
      else n.cool = m.cool - 1;
    end
    if (done) begin
      n.exist = 0; n.x = 90; n.y = 52; n.dir = 0; n.vx = 0; n.vy = 0;
      n.cool = 30; n.phase = 3;
    end
    return n;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check_out(input string name, input logic [9:0] x, y,
                           input logic e, d, input logic [7:0] h,
                           input int ex, ey, ee, ed, eh);
    vectors++;
    if (x !== 10'(ex) || y !== 10'(ey) || e !== 1'(ee) || d !== 1'(ed) ||
        h !== 8'(eh)) begin
      miscompares++;
      $display("FAIL %s: got x=%0d y=%0d exist=%0d dir=%0d hits=%0d, want x=%0d y=%0d exist=%0d dir=%0d hits=%0d",
               name, x, y, e, d, h, ex, ey, ee, ed, eh);
    end
  endtask

  task automatic expect_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // One frame: drive inputs, take the edge, advance both models, compare.
  task automatic tick(input int key, input int sel, input bit hit, input bit rst);
    keycode = 8'(key);
    turret_sel = 4'(sel);
    hit_deflector = hit;
    Reset = rst;
    @(posedge frame_clk);
    #1;
    ma = model_step(ma, key, sel, hit, rst, 255);
    mb = model_step(mb, key, sel, hit, rst, LONG_FLIGHT);
    check_out("model_a", ax, ay, ae, ad, ah, ma.x, ma.y, ma.exist, ma.dir, ma.hits);
    check_out("model_b", bx, by, be, bd, bh, mb.x, mb.y, mb.exist, mb.dir, mb.hits);
    $display("frame key=%02h sel=%0d hit=%0d rst=%0d | a:(%0d,%0d) e=%0d d=%0d h=%0d | b:(%0d,%0d) e=%0d d=%0d h=%0d",
             8'(key), sel, hit, rst, ax, ay, ae, ad, ah, bx, by, be, bd, bh);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int key; int sel; bit hit; bit rst;
    int ex, ey, ee, ed, eh;
  } vec_t;

  vec_t tab[13];

  initial begin
    int n;
    int r;
    int k;
    ma = model_reset();
    mb = model_reset();

    // Held fire launches once; turret moves mid-flight do nothing; reset
    // mid-flight parks the bullet; a press right after reset launches.
    tab[0]  = '{0,         4, 1'b0, 1'b1,  90, 52, 0, 0, 0};
    tab[1]  = '{KEY_SPACE, 4, 1'b0, 1'b0,  90, 52, 1, 0, 0};
    tab[2]  = '{KEY_SPACE, 4, 1'b0, 1'b0,  94, 52, 1, 0, 0};
    tab[3]  = '{KEY_SPACE, 4, 1'b0, 1'b0,  98, 52, 1, 0, 0};
    tab[4]  = '{KEY_SPACE, 4, 1'b0, 1'b0, 102, 52, 1, 0, 0};
    tab[5]  = '{KEY_SPACE, 4, 1'b0, 1'b0, 106, 52, 1, 0, 0};
    tab[6]  = '{0,         4, 1'b0, 1'b0, 110, 52, 1, 0, 0};
    tab[7]  = '{KEY_SPACE, 4, 1'b0, 1'b0, 114, 52, 1, 0, 0};
    tab[8]  = '{KEY_SPACE, 4, 1'b0, 1'b1,  90, 52, 0, 0, 0};
    tab[9]  = '{KEY_SPACE, 4, 1'b0, 1'b0,  90, 52, 1, 0, 0};
    tab[10] = '{KEY_SPACE, 4, 1'b0, 1'b0,  94, 52, 1, 0, 0};
    tab[11] = '{0,         0, 1'b0, 1'b0,  98, 52, 1, 0, 0};
    tab[12] = '{0,         8, 1'b0, 1'b0, 102, 52, 1, 0, 0};

    for (int i = 0; i < 13; i++) begin
      tick(tab[i].key, tab[i].sel, tab[i].hit, tab[i].rst);
      check_out($sformatf("table[%0d]", i), ax, ay, ae, ad, ah,
                tab[i].ex, tab[i].ey, tab[i].ee, tab[i].ed, tab[i].eh);
    end

    // Full out-and-back trip on the long-flight instance, then cooldown.
    tick(0, 4, 1'b0, 1'b1);
    tick(KEY_SPACE, 4, 1'b0, 1'b0);
    n = 0;
    do begin tick(0, 4, 1'b0, 1'b0); n++; end while (bd !== 1'b1 && n < 300);
    expect_int("wall_frames", n, 128);
    expect_int("wall_x", int'(bx), 599);
    n = 0;
    do begin tick(0, 4, 1'b0, 1'b0); n++; end while (be !== 1'b0 && n < 300);
    expect_int("return_frames", n, 148);
    check_out("retired_b", bx, by, be, bd, bh, 90, 52, 0, 0, 0);
    for (int i = 1; i <= 29; i++) tick(0, 4, 1'b0, 1'b0);
    tick(KEY_SPACE, 4, 1'b0, 1'b0);
    expect_int("fire_in_cooldown", int'(be), 0);
    tick(0, 4, 1'b0, 1'b0);
    tick(KEY_SPACE, 4, 1'b0, 1'b0);
    expect_int("fire_after_cooldown", int'(be), 1);

    // Vertical shot: clamp at the top, bounce, then time out at 255 frames.
    tick(0, 0, 1'b0, 1'b1);
    tick(KEY_SPACE, 0, 1'b0, 1'b0);
    n = 0;
    do begin
      tick(0, 0, 1'b0, 1'b0);
      n++;
      if (n <= 15)
        expect_int($sformatf("vertical_y[%0d]", n), int'(ay),
                   (n <= 13) ? 52 - 4 * n : ((n == 14) ? 0 : 4 * (n - 14)));
    end while (ae !== 1'b0 && n < 300);
    expect_int("vertical_lifetime", n, 255);

    // Deflector and right wall in the same frame, then a deflector on return.
    tick(0, 4, 1'b0, 1'b1);
    tick(KEY_SPACE, 4, 1'b0, 1'b0);
    for (int i = 0; i < 127; i++) tick(0, 4, 1'b0, 1'b0);
    expect_int("pre_wall_x", int'(ax), 598);
    tick(0, 4, 1'b1, 1'b0);
    check_out("wall_and_deflector", ax, ay, ae, ad, ah, 598, 52, 1, 1, 1);
    for (int i = 0; i < 3; i++) tick(0, 4, 1'b0, 1'b0);
    tick(0, 4, 1'b1, 1'b0);
    check_out("deflector_on_return", ax, ay, ae, ad, ah, 582, 52, 1, 1, 1);

    // Randomized traffic against the model.
    tick(0, 4, 1'b0, 1'b1);
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 3);
      k = (r == 0) ? 0 : ((r == 3) ? 4 : KEY_SPACE);
      tick(k, $urandom_range(0, 15), ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 999) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/projectile_ctrl.md
PROJECTILE_CTRL -- requirements
Module: projectile_ctrl

Interface
REQ-001 SHALL have parameter LAUNCH_X, default 90, launch X of bullet sprite top-left.
REQ-002 SHALL have parameter LAUNCH_Y, default 52, launch Y of bullet sprite top-left.
REQ-003 SHALL have parameter COOLDOWN, default 30, frames between bullet retirement and next fire.
REQ-004 SHALL have parameter MAX_FLIGHT, default 255, frame limit on one flight.
REQ-005 SHALL have port frame_clk, input, 1, the only clock; one edge per video frame.
REQ-006 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port keycode, input, 8, current USB keycode; 8'h2C is the space bar (fire).
REQ-008 SHALL have port turret_sel, input, 4, turret angle index 0..8; values 9..15 are treated as 4.
REQ-009 SHALL have port hit_deflector, input, 1, collision flag from the renderer, sampled each frame.
REQ-010 SHALL have port b_pos_x, output, 10, bullet X; drives the renderer bullet position.
REQ-011 SHALL have port b_pos_y, output, 10, bullet Y.
REQ-012 SHALL have port b_exist, output, 1, bullet drawn when 1.
REQ-013 SHALL have port b_dir, output, 1, 0 = outbound (right), 1 = returning (left); selects the 0 or 180 sprite.
REQ-014 SHALL have port hit_count, output, 8, count of deflector reflections, saturating at 255.

Function
REQ-015 SHALL implement the states IDLE, FLY, RETURN and CDOWN, all registered on frame_clk.
REQ-016 SHALL detect fire as a rising edge: keycode==8'h2C this frame and keycode!=8'h2C on the previous frame.
REQ-017 In IDLE, a fire edge SHALL latch turret_sel, load velocity (vx,vy), set position to (LAUNCH_X,LAUNCH_Y), set b_exist=1 and b_dir=0, and enter FLY.
REQ-018 Velocity table (signed 4-bit, per frame) by index SHALL be: 0:(0,-4) 1:(2,-3) 2:(3,-3) 3:(4,-2) 4:(4,0) 5:(4,2) 6:(3,3) 7:(2,3) 8:(0,4).
REQ-019 In FLY or RETURN, next position SHALL be computed as 11-bit signed pos+v; the registered position SHALL update once per frame.
REQ-020 Y bounds: next_y<0 SHALL set y=0 and negate vy; next_y>469 SHALL set y=469 and negate vy.
REQ-021 In FLY, next_x>=599 SHALL set x=599, negate vx, set b_dir=1 and enter RETURN.
REQ-022 In FLY, hit_deflector=1 SHALL keep x unchanged, negate vx and vy, set b_dir=1, increment hit_count (saturating) and enter RETURN.
REQ-023 If the right-wall condition and hit_deflector occur in the same frame, there SHALL be one reversal only, and hit_count SHALL increment.
REQ-024 In RETURN, hit_deflector SHALL be ignored.
REQ-025 In RETURN, next_x<=10 SHALL retire the bullet: b_exist=0, position back to launch, b_dir=0, cooldown counter=COOLDOWN, enter CDOWN.
REQ-026 A flight-frame counter SHALL clear on fire, increment in FLY and RETURN, and retire the bullet as in REQ-025 when it reaches MAX_FLIGHT. This covers vx=0 shots.
REQ-027 CDOWN SHALL decrement the counter each frame and enter IDLE on the frame the counter reaches 0.
REQ-028 Fire edges outside IDLE SHALL be ignored and not queued.
REQ-029 turret_sel changes during flight SHALL NOT affect the current bullet.

Reset
REQ-030 Reset=1 at a frame_clk edge SHALL force, from any state including mid-flight: IDLE, b_pos=(LAUNCH_X,LAUNCH_Y), b_exist=0, b_dir=0, v=(0,0), hit_count=0, both counters 0, previous-keycode register=8'h00.
REQ-031 Reset SHALL take priority over all other events in the same frame.

Verification
REQ-032 Hold keycode=8'h2C for 5 frames with turret_sel=4 -> exactly one launch; b_exist=1; x=90,94,98,... with y=52.
REQ-033 Fire with turret_sel=4, no deflector -> x reaches 599, b_dir=1, then returns; when x<=10, b_exist=0; 30 frames later a new fire is accepted.
REQ-034 Fire with turret_sel=0 -> y counts 52,48,...,4,0 and then bounces to 4; bullet retires after 255 frames.
REQ-035 hit_deflector pulsed in FLY together with the right-wall condition -> one reversal, hit_count=1; a second pulse in RETURN leaves hit_count=1.
REQ-036 Reset asserted mid-flight -> on the next edge: IDLE, b_exist=0, position (90,52), hit_count=0; a fire edge one frame after reset deasserts launches normally.
